// File: rtl/universal_shift_reg_if.sv
// Bus bundle for the universal shift register: control, serial and
// parallel data in, registered contents and frame status out.
interface universal_shift_reg_if #(
  parameter int WIDTH = 8
);
  localparam int CNT_W = $clog2(WIDTH);

  logic             en;
  logic [2:0]       mode;
  logic             ser_in_l;
  logic             ser_in_r;
  logic [WIDTH-1:0] par_in;
  logic [WIDTH-1:0] par_out;
  logic             ser_out;
  logic             word_done;
  logic [CNT_W-1:0] shift_cnt;

  modport master (
    output en, mode, ser_in_l, ser_in_r, par_in,
    input  par_out, ser_out, word_done, shift_cnt
  );

  modport slave (
    input  en, mode, ser_in_l, ser_in_r, par_in,
    output par_out, ser_out, word_done, shift_cnt
  );
endinterface

// File: rtl/universal_shift_reg.sv
// Universal shift register: hold, logical shift, rotate, parallel load and
// clear, with a frame counter that pulses word_done after every WIDTH
// shift/rotate operations since the last load, clear or frame wrap.
module universal_shift_reg #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic                   clk,
  input logic                   reset,
  universal_shift_reg_if.slave  bus
);
  localparam int               CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_SHL   = 3'b001,
    MODE_SHR   = 3'b010,
    MODE_ROL   = 3'b011,
    MODE_ROR   = 3'b100,
    MODE_LOAD  = 3'b101,
    MODE_CLEAR = 3'b110,
    MODE_RSVD  = 3'b111
  } mode_e;

  logic [WIDTH-1:0] par_q, par_d;
  logic             ser_q, ser_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_shift;

  // Decode the operation into next register contents, serial bit and frame count.
  always_comb begin
    par_d    = par_q;
    ser_d    = ser_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    is_shift = 1'b0;
    if (bus.en) begin
      case (mode_e'(bus.mode))
        MODE_SHL: begin
          par_d    = {par_q[WIDTH-2:0], bus.ser_in_l};
          ser_d    = par_q[WIDTH-1];
          is_shift = 1'b1;
        end
        MODE_SHR: begin
          par_d    = {bus.ser_in_r, par_q[WIDTH-1:1]};
          ser_d    = par_q[0];
          is_shift = 1'b1;
        end
        MODE_ROL: begin
          par_d    = {par_q[WIDTH-2:0], par_q[WIDTH-1]};
          ser_d    = par_q[WIDTH-1];
          is_shift = 1'b1;
        end
        MODE_ROR: begin
          par_d    = {par_q[0], par_q[WIDTH-1:1]};
          ser_d    = par_q[0];
          is_shift = 1'b1;
        end
        MODE_LOAD: begin
          par_d = bus.par_in;
          cnt_d = '0;
        end
        MODE_CLEAR: begin
          par_d = '0;
          ser_d = 1'b0;
          cnt_d = '0;
        end
        default: begin
          par_d = par_q;
        end
      endcase
    end
    if (is_shift) begin
      if (cnt_q == LAST) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d  = cnt_q + CNT_W'(1);
      end
    end
  end

  // Register all state; synchronous reset overrides any operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      par_q  <= RESET_VAL;
      ser_q  <= 1'b0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      par_q  <= par_d;
      ser_q  <= ser_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign bus.par_out   = par_q;
  assign bus.ser_out   = ser_q;
  assign bus.shift_cnt = cnt_q;
  assign bus.word_done = done_q;
endmodule

// File: tb/tb_universal_shift_reg.sv
// Self-checking bench for universal_shift_reg: directed scenarios with fixed
// expected values plus a randomized run against a behavioural model.
module tb_universal_shift_reg;
  localparam int           W     = 8;
  localparam int           CNT_W = $clog2(W);
  localparam int           FULL  = 1 << W;
  localparam logic [W-1:0] RVAL  = 8'h5A;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  int   m_par;
  int   m_ser;
  int   m_cnt;
  int   m_done;

  logic [W+CNT_W+1:0] obs;
  logic [W+CNT_W+1:0] exp;

  universal_shift_reg_if #(.WIDTH(W)) bus ();

  universal_shift_reg #(.WIDTH(W), .RESET_VAL(RVAL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {bus.par_out, bus.ser_out, bus.shift_cnt, bus.word_done};

  // Drive one cycle of stimulus, let the edge pass and advance the model.
  task automatic step(input logic r, input logic e, input logic [2:0] m,
                      input logic sl, input logic sr, input logic [W-1:0] pi);
    int msb;
    int lsb;
    reset        = r;
    bus.en       = e;
    bus.mode     = m;
    bus.ser_in_l = sl;
    bus.ser_in_r = sr;
    bus.par_in   = pi;
    @(posedge clk);
    #1;
    msb = m_par / (FULL / 2);
    lsb = m_par % 2;
    if (r) begin
      m_par = int'(RVAL); m_ser = 0; m_cnt = 0; m_done = 0;
    end else if (!e || m == 3'd0 || m == 3'd7) begin
      m_done = 0;
    end else if (m == 3'd5) begin
      m_par = int'(pi); m_cnt = 0; m_done = 0;
    end else if (m == 3'd6) begin
      m_par = 0; m_ser = 0; m_cnt = 0; m_done = 0;
    end else begin
      case (m)
        3'd1: begin m_ser = msb; m_par = (m_par * 2 + int'(sl)) % FULL; end
        3'd2: begin m_ser = lsb; m_par = m_par / 2 + int'(sr) * (FULL / 2); end
        3'd3: begin m_ser = msb; m_par = (m_par * 2 + msb) % FULL; end
        default: begin m_ser = lsb; m_par = m_par / 2 + lsb * (FULL / 2); end
      endcase
      m_cnt  = m_cnt + 1;
      m_done = (m_cnt == W) ? 1 : 0;
      if (m_cnt == W) m_cnt = 0;
    end
    exp = {W'(m_par), m_ser[0], CNT_W'(m_cnt), m_done[0]};
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, '0);
    checks++;
    if (obs !== {RVAL, 1'b0, 3'd0, 1'b0}) begin
      failures++;
      $display("[TB] FAIL reset: got %h expected %h", obs, {RVAL, 1'b0, 3'd0, 1'b0});
    end
    step(1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 8'hA5);
    checks++;
    if (obs !== {8'hA5, 1'b0, 3'd0, 1'b0}) begin
      failures++;
      $display("[TB] FAIL load_a5: got %h expected %h", obs, {8'hA5, 1'b0, 3'd0, 1'b0});
    end
  endtask

  task automatic test_shift_left();
    logic [7:0] sl_bits;
    logic [7:0] so_bits;
    sl_bits = 8'b1011_0010;
    so_bits = 8'b1010_0101;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 3'd1, sl_bits[7-i], 1'b0, '0);
      checks++;
      if ({bus.ser_out, bus.shift_cnt, bus.word_done} !==
          {so_bits[7-i], 3'((i + 1) % 8), (i == 7)}) begin
        failures++;
        $display("[TB] FAIL shl_step%0d: got ser/cnt/done %b/%0d/%b expected %b/%0d/%b",
                 i, bus.ser_out, bus.shift_cnt, bus.word_done,
                 so_bits[7-i], (i + 1) % 8, (i == 7));
      end
    end
    checks++;
    if (bus.par_out !== 8'hB2) begin
      failures++;
      $display("[TB] FAIL shl_final: got %h expected b2", bus.par_out);
    end
    step(1'b0, 1'b1, 3'd1, 1'b0, 1'b0, '0);
    checks++;
    if (bus.word_done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL done_single_pulse: got %b expected 0", bus.word_done);
    end
  endtask

  task automatic test_rotate();
    step(1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 8'h81);
    step(1'b0, 1'b1, 3'd4, 1'b0, 1'b0, '0);
    checks++;
    if (obs !== {8'hC0, 1'b1, 3'd1, 1'b0}) begin
      failures++;
      $display("[TB] FAIL ror: got %h expected %h", obs, {8'hC0, 1'b1, 3'd1, 1'b0});
    end
    step(1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 8'h81);
    step(1'b0, 1'b1, 3'd3, 1'b0, 1'b0, '0);
    checks++;
    if (obs !== {8'h03, 1'b1, 3'd1, 1'b0}) begin
      failures++;
      $display("[TB] FAIL rol: got %h expected %h", obs, {8'h03, 1'b1, 3'd1, 1'b0});
    end
    step(1'b0, 1'b1, 3'd2, 1'b0, 1'b1, '0);
    checks++;
    if (obs !== {8'h81, 1'b1, 3'd2, 1'b0}) begin
      failures++;
      $display("[TB] FAIL shr: got %h expected %h", obs, {8'h81, 1'b1, 3'd2, 1'b0});
    end
  endtask

  task automatic test_load_mid_frame();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 3'd1, 1'($urandom), 1'b0, '0);
    step(1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 8'h00);
    checks++;
    if (obs !== {8'h00, 1'(m_ser), 3'd0, 1'b0}) begin
      failures++;
      $display("[TB] FAIL load_mid: got %h expected %h", obs, {8'h00, 1'(m_ser), 3'd0, 1'b0});
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 3'd1 + 3'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), '0);
      checks++;
      if (bus.word_done !== (i == 7)) begin
        failures++;
        $display("[TB] FAIL frame_after_load%0d: got done %b expected %b",
                 i, bus.word_done, (i == 7));
      end
    end
  endtask

  task automatic test_enable_hold_and_reset();
    step(1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 8'h3C);
    step(1'b0, 1'b1, 3'd2, 1'b0, 1'b1, '0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 3'd2, 1'b1, 1'b1, 8'hFF);
      checks++;
      if (obs !== {8'h9E, 1'b0, 3'd1, 1'b0}) begin
        failures++;
        $display("[TB] FAIL en_low_hold%0d: got %h expected %h", i, obs, {8'h9E, 1'b0, 3'd1, 1'b0});
      end
    end
    step(1'b1, 1'b1, 3'd1, 1'b1, 1'b1, 8'hFF);
    checks++;
    if (obs !== {RVAL, 1'b0, 3'd0, 1'b0}) begin
      failures++;
      $display("[TB] FAIL reset_priority: got %h expected %h", obs, {RVAL, 1'b0, 3'd0, 1'b0});
    end
  endtask

  task automatic test_reserved_and_clear();
    step(1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 8'hFF);
    step(1'b0, 1'b1, 3'd1, 1'b1, 1'b0, '0);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 3'd7, 1'b0, 1'b0, 8'h12);
      checks++;
      if (obs !== {8'hFF, 1'b1, 3'd1, 1'b0}) begin
        failures++;
        $display("[TB] FAIL reserved_hold%0d: got %h expected %h", i, obs, {8'hFF, 1'b1, 3'd1, 1'b0});
      end
    end
    step(1'b0, 1'b1, 3'd6, 1'b1, 1'b1, 8'h77);
    checks++;
    if (obs !== {8'h00, 1'b0, 3'd0, 1'b0}) begin
      failures++;
      $display("[TB] FAIL clear: got %h expected %h", obs, {8'h00, 1'b0, 3'd0, 1'b0});
    end
  endtask

  task automatic test_random();
    step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 85),
           (($urandom_range(0, 99) < 70) ? 3'($urandom_range(1, 4)) : 3'($urandom)),
           1'($urandom), 1'($urandom), W'($urandom));
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("[TB] FAIL random%0d: got %h expected %h", i, obs, exp);
      end
    end
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    m_par        = 0;
    m_ser        = 0;
    m_cnt        = 0;
    m_done       = 0;
    exp          = '0;
    reset        = 1'b1;
    bus.en       = 1'b0;
    bus.mode     = 3'd0;
    bus.ser_in_l = 1'b0;
    bus.ser_in_r = 1'b0;
    bus.par_in   = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_shift_left();
    test_rotate();
    test_load_mid_frame();
    test_enable_hold_and_reset();
    test_reserved_and_clear();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/universal_shift_reg.md
Name: universal_shift_reg

Overview:
Parametrised universal shift register with WIDTH-bit storage and a 3-bit mode select. Supports hold, logical shift left/right, rotate left/right, parallel load and clear. A frame counter tracks shift/rotate operations and pulses word_done each time WIDTH of them have completed since the last load or clear. Used as the common serialiser/deserialiser element in serial-link and test-pattern datapaths.

Parameters:
WIDTH, 8, register width in bits; legal range WIDTH >= 2.
RESET_VAL, 0, value loaded into par_out on reset; WIDTH bits.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
en  input  1  operation enable; 0 means hold all state.
mode  input  3  operation select (encoding under Behaviour).
ser_in_l  input  1  serial bit entering bit 0 on shift left.
ser_in_r  input  1  serial bit entering bit WIDTH-1 on shift right.
par_in  input  WIDTH  parallel load data.
par_out  output  WIDTH  registered register contents.
ser_out  output  1  registered copy of the bit most recently shifted or rotated out.
word_done  output  1  one-cycle pulse; WIDTH shift/rotate ops completed.
shift_cnt  output  $clog2(WIDTH)  shift/rotate ops since last load/clear/wrap, 0..WIDTH-1.

Behaviour:
- Reset: synchronous, active-high, clock clk. Reset has priority over en and mode. On a reset edge: par_out=RESET_VAL, ser_out=0, word_done=0, shift_cnt=0.
- en=0: par_out, ser_out and shift_cnt hold. word_done=0.
- With en=1, the mode encoding is:
  - 000 hold: all state held; word_done=0.
  - 001 shift left: par_out <= {par_out[WIDTH-2:0], ser_in_l}; ser_out <= old par_out[WIDTH-1].
  - 010 shift right: par_out <= {ser_in_r, par_out[WIDTH-1:1]}; ser_out <= old par_out[0].
  - 011 rotate left: par_out <= {par_out[WIDTH-2:0], par_out[WIDTH-1]}; ser_out <= old par_out[WIDTH-1].
  - 100 rotate right: par_out <= {par_out[0], par_out[WIDTH-1:1]}; ser_out <= old par_out[0].
  - 101 load: par_out <= par_in; ser_out held; shift_cnt <= 0; word_done=0.
  - 110 clear: par_out <= 0; ser_out <= 0; shift_cnt <= 0; word_done=0.
  - 111 reserved: behaves exactly as hold.
- Frame counter, for modes 001-100 with en=1:
  - If shift_cnt == WIDTH-1: shift_cnt <= 0 and word_done <= 1.
  - Otherwise: shift_cnt <= shift_cnt+1 and word_done <= 0.
  - word_done is high in the same cycle that par_out shows the completing shift. It is never high for two consecutive cycles unless two consecutive frames complete, which is impossible for WIDTH >= 2.
- Latency: every operation is visible on the outputs one clock after the sampling edge. There is no combinational path from inputs to outputs.
- Mixed directions: shift_cnt counts every shift/rotate op regardless of direction. Mixing directions does not reset the counter.
- Load or clear mid-frame discards the partial count.
- Reset mid-frame returns all state to reset values on that edge.

Test Plan:
- WIDTH=8, reset; then en=1, mode=101, par_in=0xA5 -> next cycle par_out=0xA5, ser_out=0, shift_cnt=0, word_done=0.
- From 0xA5, 8 cycles of mode=001 with ser_in_l = 1,0,1,1,0,0,1,0 -> ser_out sequence 1,0,1,0,0,1,0,1. Final par_out=0xB2. word_done high only in the cycle after the 8th edge. shift_cnt back to 0.
- Load 0x81, one mode=100 op -> par_out=0xC0, ser_out=1, shift_cnt=1. Load 0x81, one mode=011 op -> par_out=0x03, ser_out=1.
- 3 shift-left ops (shift_cnt=3), then load 0x00, then 7 shifts -> no word_done. The 8th shift -> word_done pulses.
- mode=010 with en=0 for 4 cycles -> par_out, ser_out, shift_cnt unchanged, word_done=0. Then assert reset with en=1, mode=001 -> next cycle par_out=RESET_VAL, ser_out=0, shift_cnt=0.
- mode=111 for 2 cycles -> state held. Then mode=110 from 0xFF with ser_out=1 -> par_out=0x00, ser_out=0, shift_cnt=0.
